// File: rtl/nw_inject_arbiter.sv
// nw_inject_arbiter
// Packet-level round-robin arbiter that shares one network injection port
// among N_REQ PE-side send streams. A grant is held from HEAD to TAIL, so
// packets never interleave on the link, and a credit counter tracks free
// slots in the downstream buffer.
//
// Ports:
//   clk         clock
//   rstn        asynchronous active-low reset
//   valid_i     per-requester flit valid
//   data_i      per-requester flit, requester k at [k*`DW +: `DW]
//   ready_o     per-requester flit accept (only the owner can see it high)
//   valid_o     flit valid towards the network
//   data_o      flit towards the network (owner's flit, 0 when idle)
//   ready_i     network accept
//   credit_upd  one downstream buffer slot freed this cycle
//   grant_o     one-hot current owner, 0 when idle
//   credit_cnt  current credit count
//   err_o       sticky protocol/credit error flag

`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

module nw_inject_arbiter #(
  parameter int N_REQ       = 4,
  parameter int CREDIT_INIT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     valid_i,
  input  logic [N_REQ*`DW-1:0] data_i,
  output logic [N_REQ-1:0]     ready_o,
  output logic                 valid_o,
  output logic [`DW-1:0]       data_o,
  input  logic                 ready_i,
  input  logic                 credit_upd,
  output logic [N_REQ-1:0]     grant_o,
  output logic [7:0]           credit_cnt,
  output logic                 err_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] CREDIT_FULL = 8'(CREDIT_INIT);
  localparam logic [7:0] PKT_CREDITS = 8'(`PKT_LEN);
  localparam logic [1:0] T_HEAD = `HEAD;
  localparam logic [1:0] T_TAIL = `TAIL;
  localparam logic [N_REQ-1:0] GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_r;
  logic [IW-1:0]   owner_r;
  logic            first_r;

  logic [N_REQ-1:0] is_head_s;
  logic [N_REQ-1:0] elig_s;
  logic             credit_ge_s;
  logic             credit_ok_s;
  logic             pick_found_s;
  logic [IW-1:0]    pick_idx_s;
  int               scan_idx_s;
  logic [`DW-1:0]   owner_data_s;
  logic             owner_valid_s;
  logic [1:0]       owner_type_s;
  logic             xfer_s;
  logic             err_event_s;

  function automatic logic [1:0] flit_type(input logic [`DW-1:0] flit);
    return flit[`DW-1:`DW-2];
  endfunction

  // HEAD decode of every requester's current flit.
  always_comb begin
    is_head_s = {N_REQ{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (flit_type(data_i[k*`DW +: `DW]) == T_HEAD) begin
        is_head_s[k] = 1'b1;
      end else begin
        is_head_s[k] = 1'b0;
      end
    end
  end

  // A whole packet's worth of credit is required before a new grant.
  assign credit_ge_s = (credit_cnt >= PKT_CREDITS);
  assign credit_ok_s = (credit_cnt != 8'd0);
  assign elig_s      = credit_ge_s ? (valid_i & is_head_s) : {N_REQ{1'b0}};

  // Round-robin pick: first eligible requester scanning from rr+1 with wrap.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    scan_idx_s   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx_s = (int'(rr_r) + i) % N_REQ;
      if (!pick_found_s && elig_s[scan_idx_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IW'(scan_idx_s);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Select the current owner's flit and valid.
  always_comb begin
    owner_data_s  = {`DW{1'b0}};
    owner_valid_s = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_r == IW'(k)) begin
        owner_data_s  = data_i[k*`DW +: `DW];
        owner_valid_s = valid_i[k];
      end else begin
        owner_valid_s = owner_valid_s;
      end
    end
  end

  assign owner_type_s = flit_type(owner_data_s);

  // Network-side handshake; nothing moves while idle or out of credit.
  always_comb begin
    valid_o = 1'b0;
    data_o  = {`DW{1'b0}};
    ready_o = {N_REQ{1'b0}};
    if (state_r == LOCK) begin
      valid_o = owner_valid_s & credit_ok_s;
      data_o  = owner_data_s;
      ready_o = grant_o & {N_REQ{ready_i & credit_ok_s}};
    end else begin
      valid_o = 1'b0;
    end
  end

  assign xfer_s = valid_o & ready_i;

  // Error sources: non-HEAD start, HEAD inside a packet, credit overflow.
  assign err_event_s = ((state_r == IDLE) && |(valid_i & ~is_head_s))
                     | (xfer_s && (owner_type_s == T_HEAD) && !first_r)
                     | (credit_upd && !xfer_s && (credit_cnt == CREDIT_FULL));

  // Arbitration FSM, credit counter and sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      grant_o    <= {N_REQ{1'b0}};
      rr_r       <= IW'(N_REQ - 1);
      owner_r    <= {IW{1'b0}};
      first_r    <= 1'b0;
      credit_cnt <= CREDIT_FULL;
      err_o      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r <= LOCK;
            owner_r <= pick_idx_s;
            grant_o <= GRANT_ONE << pick_idx_s;
            first_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK: begin
          if (xfer_s) begin
            first_r <= 1'b0;
            if (owner_type_s == T_TAIL) begin
              state_r <= IDLE;
              rr_r    <= owner_r;
              grant_o <= {N_REQ{1'b0}};
            end else begin
              state_r <= LOCK;
            end
          end else begin
            state_r <= LOCK;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_o <= {N_REQ{1'b0}};
        end
      endcase

      // Overflowing increments hold the count (flagged above).
      if (credit_upd && !xfer_s) begin
        if (credit_cnt != CREDIT_FULL) begin
          credit_cnt <= credit_cnt + 8'd1;
        end else begin
          credit_cnt <= credit_cnt;
        end
      end else if (!credit_upd && xfer_s) begin
        credit_cnt <= credit_cnt - 8'd1;
      end else begin
        credit_cnt <= credit_cnt;
      end

      if (err_event_s) begin
        err_o <= 1'b1;
      end else begin
        err_o <= err_o;
      end
    end
  end

endmodule

// File: tb/tb_nw_inject_arbiter.sv
// Self-checking bench for nw_inject_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// packet-level behavioural model.

`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

module tb_nw_inject_arbiter;

  localparam int N   = 4;
  localparam int CI  = 16;
  localparam int DWB = `DW;
  localparam int PKT = `PKT_LEN;
  localparam logic [1:0] TH = `HEAD;
  localparam logic [1:0] TB = `BODY;
  localparam logic [1:0] TT = `TAIL;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   valid_i;
  logic [N*DWB-1:0] data_i;
  logic [N-1:0]   ready_o;
  logic           valid_o;
  logic [DWB-1:0] data_o;
  logic           ready_i;
  logic           credit_upd;
  logic [N-1:0]   grant_o;
  logic [7:0]     credit_cnt;
  logic           err_o;

  nw_inject_arbiter #(.N_REQ(N), .CREDIT_INIT(CI)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .credit_upd(credit_upd), .grant_o(grant_o), .credit_cnt(credit_cnt),
    .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-requester flit queues (front = flit currently offered).
  logic [DWB-1:0] q [N][$];
  logic [N-1:0]   acc_mask = '0;
  int vprob = 100, rprob = 100, cprob = 0;
  bit cu_force = 1'b0;

  // Model state
  int m_owner = -1;
  int m_rr    = N-1;
  int m_credit = CI;
  bit m_err   = 1'b0;
  bit m_first = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [DWB-1:0] mk(input logic [1:0] t, input logic [DWB-3:0] p);
    return {t, p};
  endfunction

  function automatic logic [1:0] ftype(input int k);
    logic [DWB-1:0] f;
    f = data_i[k*DWB +: DWB];
    return f[DWB-1:DWB-2];
  endfunction

  task automatic push_pkt(input int k, input int len);
    q[k].push_back(mk(TH, (DWB-2)'($urandom)));
    for (int i = 1; i < len-1; i++) q[k].push_back(mk(TB, (DWB-2)'($urandom)));
    q[k].push_back(mk(TT, (DWB-2)'($urandom)));
  endtask

  // Compare DUT against the model, then advance the model over the next edge.
  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_grant;
    logic e_valid, xfer;
    logic [DWB-1:0] e_data;
    logic [1:0] t;
    int kk;
    bit was_idle;
    if (!rstn) begin
      m_owner = -1; m_rr = N-1; m_credit = CI; m_err = 1'b0; m_first = 1'b0;
    end
    e_valid = 1'b0; e_ready = '0; e_data = '0; e_grant = '0;
    if (rstn && m_owner >= 0) begin
      e_grant = '0; e_grant[m_owner] = 1'b1;
      e_valid = valid_i[m_owner] && (m_credit > 0);
      e_data  = data_i[m_owner*DWB +: DWB];
      if (ready_i && m_credit > 0) e_ready[m_owner] = 1'b1;
    end
    check("grant", grant_o, e_grant);
    check("credit", credit_cnt, m_credit[7:0]);
    check("err", err_o, m_err);
    check("valid_o", valid_o, e_valid);
    check("ready_o", ready_o, e_ready);
    check("data_o", data_o, e_data);
    acc_mask = '0;
    if (rstn) begin
      xfer = e_valid && ready_i;
      was_idle = (m_owner < 0);
      if (was_idle) begin
        for (int k = 0; k < N; k++) if (valid_i[k] && ftype(k) != TH) m_err = 1'b1;
        if (m_credit >= PKT) begin
          for (int s = 1; s <= N; s++) begin
            kk = (m_rr + s) % N;
            if (valid_i[kk] && ftype(kk) == TH) begin
              m_owner = kk; m_first = 1'b1;
              break;
            end
          end
        end
      end else if (xfer) begin
        acc_mask[m_owner] = 1'b1;
        t = ftype(m_owner);
        if (t == TH && !m_first) m_err = 1'b1;
        m_first = 1'b0;
        if (t == TT) begin m_rr = m_owner; m_owner = -1; end
      end
      m_credit = m_credit + (credit_upd ? 1 : 0) - (xfer ? 1 : 0);
      if (m_credit > CI) begin m_credit = CI; m_err = 1'b1; end
    end
  end

  // Advance one cycle: retire accepted flits, then drive the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (acc_mask[k] && q[k].size() > 0) void'(q[k].pop_front());
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0 && $urandom_range(99) < vprob) begin
        valid_i[k] = 1'b1;
        data_i[k*DWB +: DWB] = q[k][0];
      end else begin
        valid_i[k] = 1'b0;
        data_i[k*DWB +: DWB] = $urandom;
      end
    end
    ready_i = ($urandom_range(99) < rprob);
    credit_upd = cu_force || ((m_credit < CI) && ($urandom_range(99) < cprob));
  endtask

  task automatic do_reset();
    rstn = 1'b0; valid_i = '0; data_i = '0; ready_i = 1'b0; credit_upd = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  logic [N-1:0] gseq[$];
  logic [N-1:0] rr_exp [5];
  logic [N-1:0] prev_g;
  logic [DWB-1:0] b1;

  initial begin
    rstn = 1'b0; valid_i = '0; data_i = '0; ready_i = 1'b0; credit_upd = 1'b0;

    // Single packet from req0
    do_reset();
    #1;
    check("rst_grant", grant_o, 4'b0000);
    check("rst_credit", credit_cnt, 8'd16);
    vprob = 100; rprob = 100; cprob = 0;
    push_pkt(0, 4);
    step();
    step(); #1;
    check("single_grant", grant_o, 4'b0001);
    check("single_valid", valid_o, 1'b1);
    repeat (4) step();
    #1;
    check("single_credit", credit_cnt, 8'd12);
    check("single_idle", grant_o, 4'b0000);

    // Round robin across all requesters
    do_reset();
    cprob = 50;
    for (int k = 0; k < N; k++) begin push_pkt(k, 2); push_pkt(k, 2); end
    prev_g = '0;
    gseq.delete();
    for (int c = 0; c < 25; c++) begin
      step(); #1;
      if (grant_o != '0 && prev_g == '0) gseq.push_back(grant_o);
      prev_g = grant_o;
    end
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++)
      check("rr_order", (gseq.size() > i) ? gseq[i] : 4'b0000, rr_exp[i]);

    // Credit stall: drain all credits, then refill one by one
    do_reset();
    cprob = 0;
    for (int p = 0; p < 5; p++) push_pkt(1, 4);
    repeat (30) step();
    #1;
    check("stall_credit0", credit_cnt, 8'd0);
    check("stall_nogrant", grant_o, 4'b0000);
    check("stall_pending", q[1].size(), 4);
    cprob = 100;
    repeat (4) step();
    #1;
    check("stall_credit3", credit_cnt, 8'd3);
    check("stall_wait3", grant_o, 4'b0000);
    cprob = 0;
    step(); #1;
    check("stall_credit4", credit_cnt, 8'd4);
    check("stall_wait4", grant_o, 4'b0000);
    step(); #1;
    check("stall_grant", grant_o, 4'b0010);

    // Backpressure mid-packet, then transfer with a simultaneous credit return
    do_reset();
    b1 = mk(TB, 30'h22);
    q[3].push_back(mk(TH, 30'h11));
    q[3].push_back(b1);
    q[3].push_back(mk(TB, 30'h33));
    q[3].push_back(mk(TT, 30'h44));
    step();
    step();
    rprob = 0;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      check("bp_data", data_o, b1);
      check("bp_ready", ready_o, 4'b0000);
      check("bp_credit", credit_cnt, 8'd15);
    end
    rprob = 100; cprob = 100;
    step();
    cprob = 0;
    step(); #1;
    check("simul_credit", credit_cnt, 8'd15);
    check("simul_next", data_o, mk(TB, 30'h33));

    // Errors: BODY at an idle requester, then credit overflow
    do_reset();
    q[2].push_back(mk(TB, 30'h55));
    step();
    step(); #1;
    check("body_nogrant", grant_o, 4'b0000);
    check("body_err", err_o, 1'b1);
    do_reset();
    #1;
    check("err_cleared", err_o, 1'b0);
    cu_force = 1'b1;
    step();
    cu_force = 1'b0;
    step(); #1;
    check("ovf_credit", credit_cnt, 8'd16);
    check("ovf_err", err_o, 1'b1);

    // Reset mid-packet
    do_reset();
    push_pkt(0, 4);
    repeat (4) step();
    rstn = 1'b0;
    #1;
    check("midrst_grant", grant_o, 4'b0000);
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_credit", credit_cnt, 8'd16);
    do_reset();
    push_pkt(1, 4);
    push_pkt(0, 4);
    step();
    step(); #1;
    check("midrst_first", grant_o, 4'b0001);

    // Randomized traffic
    do_reset();
    vprob = 80; rprob = 75; cprob = 40;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      for (int k = 0; k < N; k++)
        if (q[k].size() == 0 && $urandom_range(99) < 20) push_pkt(k, $urandom_range(2, 6));
      step();
    end
    step();
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
